// File: rtl/knn_query_driver.sv
// knn_query_driver: buffers queries, runs the classifier start/done
// handshake one query at a time and returns tagged results.
module knn_query_driver #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_FEATURES   = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int DEFAULT_K      = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               q_valid,
  output logic                               q_ready,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0] q_data,
  input  logic [DATA_WIDTH-1:0]              q_k,
  output logic                               clf_start,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0] clf_test_data,
  output logic [DATA_WIDTH-1:0]              clf_k_value,
  input  logic                               clf_done,
  input  logic                               clf_class,
  output logic                               r_valid,
  input  logic                               r_ready,
  output logic                               r_class,
  output logic [7:0]                         r_tag,
  output logic                               r_timeout,
  output logic                               busy
);

  localparam int QW = DATA_WIDTH * NUM_FEATURES;
  localparam int EW = QW + DATA_WIDTH;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT =
    CW'(QUEUE_DEPTH);
  localparam logic [11:0] TO_LAST =
    12'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] DEF_K =
    DATA_WIDTH'(DEFAULT_K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_RESULT,
    S_RECOVER
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EW-1:0]   r_mem [QUEUE_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic [DATA_WIDTH-1:0] w_k_in;
  logic [EW-1:0]   w_head;

  logic            r_start;
  logic [QW-1:0]   r_tdata;
  logic [DATA_WIDTH-1:0] r_kval;
  logic [11:0]     r_timer;
  logic            r_cls;
  logic            r_to;
  logic [7:0]      r_tagc;
  logic            r_seen;

  logic            w_cap;
  logic            w_tmo;
  logic            w_tinc;
  logic            w_acc;

  assign q_ready = (r_count != FULL_CNT);
  assign w_push  = q_valid & q_ready;
  assign w_k_in  = (q_k == '0) ? DEF_K : q_k;
  assign w_head  = r_mem[r_rptr];

  // Query storage; entries need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_k_in, q_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cap  = 1'b0;
    w_tmo  = 1'b0;
    w_tinc = 1'b0;
    w_acc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0 && !clf_done) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (clf_done) begin
          w_cap  = 1'b1;
          w_next = S_WAIT_LOW;
        end else if (r_timer == TO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_RESULT;
        end else begin
          w_tinc = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!clf_done) w_next = S_RESULT;
      end
      S_RESULT: begin
        if (r_ready) begin
          w_acc  = 1'b1;
          w_next = r_to ? S_RECOVER : S_IDLE;
        end
      end
      S_RECOVER: begin
        if (r_seen && !clf_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Classifier-side registers: start, operands, timeout timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= 1'b0;
      r_tdata <= '0;
      r_kval  <= '0;
      r_timer <= '0;
    end else begin
      if (w_pop) begin
        r_start <= 1'b1;
        r_tdata <= w_head[QW-1:0];
        r_kval  <= w_head[EW-1:QW];
        r_timer <= '0;
      end else if (w_cap || w_tmo) begin
        r_start <= 1'b0;
      end else if (w_tinc) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Result capture and tag sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cls  <= 1'b0;
      r_to   <= 1'b0;
      r_tagc <= '0;
    end else begin
      if (w_cap) begin
        r_cls <= clf_class;
        r_to  <= 1'b0;
      end else if (w_tmo) begin
        r_cls <= 1'b0;
        r_to  <= 1'b1;
      end
      if (w_acc) r_tagc <= r_tagc + 8'd1;
    end
  end

  // Tracks the rising half of a late done pulse while recovering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen <= 1'b0;
    end else if (r_state != S_RECOVER) begin
      r_seen <= 1'b0;
    end else if (clf_done) begin
      r_seen <= 1'b1;
    end
  end

  assign clf_start     = r_start;
  assign clf_test_data = r_tdata;
  assign clf_k_value   = r_kval;
  assign r_valid       = (r_state == S_RESULT);
  assign r_class       = r_cls;
  assign r_tag         = r_tagc;
  assign r_timeout     = r_to;
  assign busy          = (r_state != S_IDLE) ||
                         (r_count != '0);

endmodule

// File: tb/tb_knn_query_driver.sv
// tb_knn_query_driver: directed vectors against a
// behavioural classifier with fixed latency 20.
module tb_knn_query_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [15:0] q_data;
  logic [7:0]  q_k;
  logic        clf_start;
  logic [15:0] clf_test_data;
  logic [7:0]  clf_k_value;
  logic        clf_done;
  logic        clf_class;
  logic        r_valid;
  logic        r_ready;
  logic        r_class;
  logic [7:0]  r_tag;
  logic        r_timeout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic m_done;
  logic m_cls;
  logic m_hang;
  logic late_done;
  int   m_cnt;

  always #5 clk = ~clk;

  knn_query_driver dut (
    .clk           (clk),
    .rst           (rst),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .q_data        (q_data),
    .q_k           (q_k),
    .clf_start     (clf_start),
    .clf_test_data (clf_test_data),
    .clf_k_value   (clf_k_value),
    .clf_done      (clf_done),
    .clf_class     (clf_class),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_class       (r_class),
    .r_tag         (r_tag),
    .r_timeout     (r_timeout),
    .busy          (busy)
  );

  assign clf_done  = m_done | late_done;
  assign clf_class = m_cls;

  // Classifier: done 20 cycles into start, class = (f1+f2 > 6).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done <= 1'b0;
      m_cls  <= 1'b0;
      m_cnt  <= 0;
    end else if (clf_start && !m_done) begin
      if (!m_hang) begin
        if (m_cnt == 19) begin
          m_done <= 1'b1;
          m_cls  <= ({1'b0, clf_test_data[15:8]} +
                     {1'b0, clf_test_data[7:0]}) > 9'd6;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (!clf_start) begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] f1,
                      input logic [7:0] f2,
                      input logic [7:0] k);
    bit ok;
    ok = 1'b0;
    q_valid = 1'b1;
    q_data  = {f1, f2};
    q_k     = k;
    for (int i = 0; i < 200; i++) begin
      if (q_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("push_wait", 32'(ok), 32'd1);
    tick();
    q_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (clf_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rv(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (r_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  logic [7:0] bf1 [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] bf2 [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  logic       bcl [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int nst;
    int bad;
    rst       = 1'b0;
    q_valid   = 1'b0;
    q_data    = '0;
    q_k       = '0;
    r_ready   = 1'b0;
    m_hang    = 1'b0;
    late_done = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_start", 32'(clf_start), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(r_tag), 32'd0);
    chk("rst_k", 32'(clf_k_value), 32'd0);
    rst = 1'b1;
    tick();
    tick();

    // single query, result held with r_ready low
    push(8'd3, 8'd4, 8'd3);
    chk("s1_start_lo", 32'(clf_start), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_start_hi", 32'(clf_start), 32'd1);
    chk("s1_data", 32'(clf_test_data), 32'h0304);
    chk("s1_k", 32'(clf_k_value), 32'd3);
    nst = 0;
    for (int i = 0; i < 100; i++) begin
      if (r_valid) break;
      if (clf_start) nst++;
      tick();
    end
    chk("s1_rvalid", 32'(r_valid), 32'd1);
    chk("s1_start_cyc", 32'(nst), 32'd21);
    chk("s1_tag", 32'(r_tag), 32'd0);
    chk("s1_class", 32'(r_class), 32'd1);
    chk("s1_tmo", 32'(r_timeout), 32'd0);
    chk("s1_done_lo", 32'(clf_done), 32'd0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (r_valid !== 1'b1 || r_tag !== 8'd0 ||
          r_class !== 1'b1 || clf_start !== 1'b0)
        bad++;
    end
    chk("s1_stall", 32'(bad), 32'd0);
    r_ready = 1'b1;
    tick();
    chk("s1_consumed", 32'(r_valid), 32'd0);
    chk("s1_idle", 32'(busy), 32'd0);

    // k substitution
    push(8'd1, 8'd1, 8'd0);
    wait_start("k0_start");
    chk("k0_kval", 32'(clf_k_value), 32'd3);
    chk("k0_data", 32'(clf_test_data), 32'h0101);
    wait_rv("k0_rv");
    chk("k0_class", 32'(r_class), 32'd0);
    chk("k0_tag", 32'(r_tag), 32'd1);
    tick();
    push(8'd9, 8'd9, 8'd7);
    wait_start("k7_start");
    chk("k7_kval", 32'(clf_k_value), 32'd7);
    wait_rv("k7_rv");
    chk("k7_class", 32'(r_class), 32'd1);
    chk("k7_tag", 32'(r_tag), 32'd2);
    tick();

    // five back-to-back queries
    for (int i = 0; i < 5; i++) push(bf1[i], bf2[i], 8'd3);
    chk("b_full", 32'(q_ready), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_rv("b_rv");
      chk("b_tag", 32'(r_tag), 32'(3 + i));
      chk("b_class", 32'(r_class), 32'(bcl[i]));
      tick();
    end

    // done timeout, then recovery from a late pulse
    m_hang = 1'b1;
    push(8'd5, 8'd5, 8'd3);
    wait_start("t_start");
    nst = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!clf_start) break;
      nst++;
      tick();
    end
    chk("t_cycles", 32'(nst), 32'd4095);
    chk("t_rvalid", 32'(r_valid), 32'd1);
    chk("t_tmo", 32'(r_timeout), 32'd1);
    chk("t_class", 32'(r_class), 32'd0);
    chk("t_tag", 32'(r_tag), 32'd8);
    m_hang = 1'b0;
    push(8'd6, 8'd6, 8'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (clf_start !== 1'b0) bad++;
      tick();
    end
    chk("t_no_issue", 32'(bad), 32'd0);
    chk("t_busy", 32'(busy), 32'd1);
    late_done = 1'b1;
    tick();
    tick();
    late_done = 1'b0;
    wait_start("t_restart");
    chk("t_data", 32'(clf_test_data), 32'h0606);
    wait_rv("t_rv2");
    chk("t2_class", 32'(r_class), 32'd1);
    chk("t2_tmo", 32'(r_timeout), 32'd0);
    chk("t2_tag", 32'(r_tag), 32'd9);
    tick();

    // reset in the middle of an issue with 3 queued
    push(8'd1, 8'd2, 8'd3);
    push(8'd2, 8'd3, 8'd3);
    push(8'd3, 8'd4, 8'd3);
    push(8'd4, 8'd5, 8'd3);
    tick();
    tick();
    tick();
    chk("r_mid_start", 32'(clf_start), 32'd1);
    rst = 1'b0;
    #1;
    chk("r_start", 32'(clf_start), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_qready", 32'(q_ready), 32'd1);
    chk("r_data", 32'(clf_test_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("r_empty", 32'(busy), 32'd0);
    push(8'd3, 8'd4, 8'd3);
    wait_rv("r_rv");
    chk("r_tag0", 32'(r_tag), 32'd0);
    chk("r_class", 32'(r_class), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
